// File: rtl/neuron_mac_pkg.sv
// Shared defaults, Q-format split and saturation helpers for the neuron MAC.
// Helpers work on a 64-bit signed carrier, so 2*dataWidth must stay below 64.
package neuron_mac_pkg;

  localparam int NUM_WEIGHT_DEF = 784;
  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 16;
  localparam int INT_W_DEF      = 4;
  localparam int FRAC_W_DEF     = DATA_W_DEF - INT_W_DEF;
  localparam int SAT_MAXW       = 64;

  typedef logic signed [SAT_MAXW-1:0] wide_t;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic wide_t sat_clamp(input wide_t x, input int w);
    wide_t hi;
    wide_t lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

  // Operands are in w-bit range, so the carrier sum is exact before clamping.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
    return sat_clamp(a + b, w);
  endfunction

endpackage

// File: rtl/neuron_mac_sat_adder.sv
// Parameterized signed saturating adder.
module sat_adder
  import neuron_mac_pkg::*;
#(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  wide_t r;

  assign r = sat_add(SAT_MAXW'(a), SAT_MAXW'(b), W);
  assign y = W'(r);

endmodule

// File: rtl/neuron_mac.sv
// One fully-connected neuron: weight-memory read addressing, pipelined multiply,
// saturating accumulate, bias add and requantization back to dataWidth.
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int numWeight    = NUM_WEIGHT_DEF,
  parameter int addressWidth = ADDR_W_DEF,
  parameter int dataWidth    = DATA_W_DEF,
  parameter int intWidth     = INT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [dataWidth-1:0]    myinput,
  input  logic                    myinputValid,
  input  logic                    biasWen,
  input  logic [dataWidth-1:0]    biasIn,
  output logic                    ren,
  output logic [addressWidth-1:0] radd,
  input  logic [dataWidth-1:0]    wout,
  output logic [dataWidth-1:0]    outData,
  output logic                    outValid
);

  localparam int F  = dataWidth - intWidth;
  localparam int PW = 2 * dataWidth;
  localparam int STAGES = 2;

  logic [addressWidth-1:0] rAddr;
  logic                    last0;
  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0]         last_pipe;

  logic signed [dataWidth-1:0] x_d, x_q, w_q, bias;
  logic signed [PW-1:0]        mul, sum, acc_next, bias_sh, biased, biased_shr;
  logic signed [dataWidth-1:0] out_next;
  logic                        fire;

  assign ren   = myinputValid;
  assign radd  = rAddr;
  assign last0 = (rAddr == addressWidth'(numWeight - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rAddr <= '0;
    end else if (myinputValid) begin
      rAddr <= last0 ? '0 : rAddr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bias <= '0;
    else if (biasWen) bias <= $signed(biasIn);
  end

  // [0]: activation captured, [1]: operands aligned with the returned weight,
  // [2]: product ready for accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      x_d       <= '0;
      x_q       <= '0;
      w_q       <= '0;
      mul       <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], myinputValid};
      last_pipe <= {last_pipe[STAGES-1:0], myinputValid & last0};
      x_d       <= $signed(myinput);
      x_q       <= x_d;
      w_q       <= $signed(wout);
      mul       <= PW'(x_q) * PW'(w_q);
    end
  end

  sat_adder #(.W(PW)) u_acc (
    .a(sum),
    .b(mul),
    .y(acc_next)
  );

  assign bias_sh = PW'(bias) <<< F;

  sat_adder #(.W(PW)) u_bias (
    .a(sum),
    .b(bias_sh),
    .y(biased)
  );

  assign biased_shr = biased >>> F;
  assign out_next   = dataWidth'(sat_clamp(SAT_MAXW'(biased_shr), dataWidth));

  // On the output cycle the accumulator restarts with the next vector's
  // first product, so back-to-back vectors need no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      fire     <= 1'b0;
      outData  <= '0;
      outValid <= 1'b0;
    end else begin
      fire     <= vld_pipe[STAGES] & last_pipe[STAGES];
      outValid <= fire;
      if (fire) begin
        outData <= out_next;
        sum     <= vld_pipe[STAGES] ? mul : '0;
      end else if (vld_pipe[STAGES]) begin
        sum <= acc_next;
      end
    end
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Multiply-accumulate datapath for one fully-connected neuron; sits directly downstream of that neuron's weight memory.
- Drives the memory's synchronous read port (`ren`/`radd`) in lock-step with the incoming activation stream.
- Multiplies each activation by its weight, accumulates with saturation, adds the neuron bias, and emits one saturated fixed-point sum per input vector.
- Activation function is applied by the following stage.

## Interface
Parameters:
- `numWeight`, 784: inputs per vector, which is also the weight memory depth.
- `addressWidth`, 10: weight memory address width; must satisfy 2^addressWidth ≥ numWeight.
- `dataWidth`, 16: signed width of activations, weights, bias and output.
- `intWidth`, 4: integer bits (including sign) of the Q format; fractional bits F = dataWidth − intWidth.

Ports:
- Clock `clk` and reset `rst_n`: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `myinput`  in  dataWidth  signed activation.
- `myinputValid`  in  1  activation valid. There is no backpressure.
- `biasWen`  in  1  load `biasIn` into the bias register.
- `biasIn`  in  dataWidth  signed bias, Q(intWidth.F).
- `ren`  out  1  weight memory read enable.
- `radd`  out  addressWidth  weight memory read address.
- `wout`  in  dataWidth  weight read data, valid 1 cycle after `ren`.
- `outData`  out  dataWidth  saturated neuron sum, Q(intWidth.F).
- `outValid`  out  1  one-cycle pulse when `outData` is new.

## Operation
- `ren` = `myinputValid` (combinational). `radd` = read counter `rAddr`.
- `rAddr` increments on each accepted input and wraps from numWeight−1 to 0.
- A `last` flag accompanies the input taken at `rAddr` = numWeight−1.
- Pipeline:
  - S1: register `x_d` ← `myinput`, and `v1`/`last1`.
  - S2: `mul` ← signed(`x_d`) × signed(`wout`), 2·dataWidth bits, with `v2`/`last2`.
  - S3: `sum` ← sat(`sum` + `mul`) when `v2`.
  - S4, one cycle after the product tagged `last2` is accumulated:
    - `outData` ← sat_dw((sat(`sum` + (sext(`bias`) <<< F))) >>> F).
    - `outValid` = 1.
    - `sum` ← `mul` if `v2`, else 0. This lets the next vector start without a gap.
- sat(a+b), 2·dataWidth signed: if the operands share a sign and the result sign differs, clamp to 0x7FF…F or 0x800…0.
- sat_dw: clamp to the signed dataWidth range.
- The bias register is written on `biasWen` at any time. The new value applies to any vector whose S4 occurs after the write.
- Reset clears `rAddr`, all pipeline valids, `sum`, `bias`, `outData`, and `outValid` to 0. A partial vector is discarded and produces no `outValid`.

## Timing
- Input sampled at edge E0 → weight returned E1 → product E2 → accumulated E3.
- For the last input of a vector, `outData`/`outValid` update at E4. Latency is 4 cycles from the last input to `outValid`.
- Inputs may arrive back-to-back or with any gaps. Gaps do not change the result.
- Consecutive vectors with no gap give `outValid` pulses exactly numWeight cycles apart.
- `outValid` is never high for two consecutive cycles unless numWeight = 1.
- Reset values of all outputs: `ren`=0 (follows input), `radd`=0, `outData`=0, `outValid`=0.

## Structure
- The shared include/package holds:
  - Default widths.
  - The Q-format split (intWidth, F).
  - The saturating add and the dataWidth clamp, as functions.
- One natural sub-module: `sat_adder`, a parameterized signed saturating adder. It is instantiated twice: accumulate and bias-add.
- The weight memory is external; this block only drives its read port.

## Test plan
Use dataWidth=16, intWidth=4 (1.0 = 0x1000), numWeight=3.
1. Weights all 0x1000, bias 0, inputs 0x0800, 0x0400, 0x0400 → `outData`=0x1000. `outValid` pulses exactly 4 cycles after the last input. `radd` sequence is 0,1,2.
2. Same inputs, bias 0x1000 loaded first → `outData`=0x2000.
3. Weights and inputs all 0x7000 (7.0) → accumulator saturates, `outData`=0x7FFF. Weights all 0x9000 (−7.0) → `outData`=0x8000.
4. Two vectors back-to-back with no gap, second using inputs 0x1000 ×3 → two single-cycle `outValid` pulses 3 cycles apart, values 0x1000 then 0x3000. `radd` is 0,1,2,0,1,2.
5. First vector with one idle cycle between each input → identical result to scenario 1. `ren` is low during the gaps.
6. Assert `rst_n` low after 2 inputs, then send a full vector → no `outValid` for the aborted vector. The next vector starts at `radd`=0 and yields the scenario 1 value.
